// File: rtl/dual_port_mem.sv
// dual_port_mem
//   Synchronous simple-dual-port memory with one write port and one read port
//   on a single clock. It tracks which entries have been written since reset
//   and flags reads of entries that were never written. Reads take one cycle.
//   The data array itself is never reset; only the tracking state is.
//
// Ports
//   clk            single clock; all state updates on the rising edge
//   reset          asynchronous, active-high
//   data_in        write data
//   addr_write     write address
//   write          write enable
//   addr_read      read address
//   read           read enable
//   data_out       registered read data; holds its value when read=0
//   valid_out      one-cycle strobe: data_out was updated by a read on the last edge
//   err_unwritten  one-cycle strobe: the last read hit a never-written entry
//   fill_count     number of distinct entries written since reset (saturating)
module dual_port_mem #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic [ADDR_BITS-1:0] addr_write,
    input  logic                 write,
    input  logic [ADDR_BITS-1:0] addr_read,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 err_unwritten,
    output logic [ADDR_BITS:0]   fill_count
);

    localparam int                 DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL  = (ADDR_BITS + 1)'(DEPTH);

    // The storage array is not reset.
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic [DEPTH-1:0]     written_q,  written_d;
    logic [ADDR_BITS:0]   fill_q,     fill_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q,    valid_d;
    logic                 err_q,      err_d;

    always_comb begin
        written_d  = written_q;
        fill_d     = fill_q;
        data_out_d = data_out_q;
        valid_d    = read;
        err_d      = 1'b0;

        if (write) begin
            written_d[addr_write] = 1'b1;
            // Count only first writes to an entry. The saturation guard is
            // defensive: distinct entries can never exceed DEPTH.
            if (!written_q[addr_write] && fill_q != FULL)
                fill_d = fill_q + 1'b1;
        end

        if (read) begin
            if (write && addr_write == addr_read) begin
                // Write-first bypass. This applies even when the write is the
                // entry's first, so no error is flagged.
                data_out_d = data_in;
            end else if (written_q[addr_read]) begin
                data_out_d = mem_q[addr_read];
            end else begin
                data_out_d = '0;
                err_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write)
            mem_q[addr_write] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written_q  <= '0;
            fill_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            written_q  <= written_d;
            fill_q     <= fill_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign data_out      = data_out_q;
    assign valid_out     = valid_q;
    assign err_unwritten = err_q;
    assign fill_count    = fill_q;

endmodule

// File: tb/tb_dual_port_mem.sv
module tb_dual_port_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [5:0] addr_write;
    logic       write;
    logic [5:0] addr_read;
    logic       read;
    logic [7:0] data_out;
    logic       valid_out;
    logic       err_unwritten;
    logic [6:0] fill_count;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t exp_q[$];

    dual_port_mem #(.DATA_BITS(8), .ADDR_BITS(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .addr_write   (addr_write),
        .write        (write),
        .addr_read    (addr_read),
        .read         (read),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .err_unwritten(err_unwritten),
        .fill_count   (fill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops one expectation per valid_out strobe.
    always @(negedge clk) begin
        if (!reset && valid_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("read_data", {24'd0, data_out}, {24'd0, e.d});
                chk("read_err", {31'd0, err_unwritten}, {31'd0, e.e});
            end
        end
    end

    // One edge of stimulus; a read pushes its expected response first.
    task automatic cyc(input logic w, input logic [5:0] aw, input logic [7:0] d,
                       input logic r, input logic [5:0] ar,
                       input logic [7:0] ed, input logic ee);
        write = w; addr_write = aw; data_in = d;
        read = r;  addr_read = ar;
        if (r) exp_q.push_back('{d: ed, e: ee});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = 1'b0; read = 1'b0;
        addr_write = 'x; data_in = 'x; addr_read = 'x;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_err", {31'd0, err_unwritten}, 32'd0);
        chk("rst_fill", {25'd0, fill_count}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0;
        data_in = '0; addr_write = '0; addr_read = '0;
        do_reset();

        // 1: read of an unwritten entry
        cyc(0, 0, 0, 1, 5, 8'h00, 1'b1);
        chk("s1_fill", {25'd0, fill_count}, 32'd0);

        // 2: write @0, then write @1 while reading @0
        cyc(1, 0, 8'hFF, 0, 0, 0, 0);
        cyc(1, 1, 8'h24, 1, 0, 8'hFF, 1'b0);
        chk("s2_fill", {25'd0, fill_count}, 32'd2);

        // 3: same-edge write/read to a never-written entry -> bypass
        cyc(1, 7, 8'hA5, 1, 7, 8'hA5, 1'b0);
        chk("s3_fill", {25'd0, fill_count}, 32'd3);
        // different-address concurrent write/read
        cyc(1, 9, 8'h33, 1, 1, 8'h24, 1'b0);
        chk("s3_fill_b", {25'd0, fill_count}, 32'd4);

        // 4: rewrite @3, fill counts it once; data_out holds on idle
        do_reset();
        cyc(1, 3, 8'h11, 0, 0, 0, 0);
        cyc(1, 3, 8'h22, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 8'h22, 1'b0);
        chk("s4_fill", {25'd0, fill_count}, 32'd1);
        idle();
        chk("s4_hold_data", {24'd0, data_out}, 32'h22);
        chk("s4_idle_valid", {31'd0, valid_out}, 32'd0);

        // 5: fill all 64 entries, read back, then saturate
        do_reset();
        for (int i = 0; i < 64; i++) cyc(1, 6'(i), 8'(i) ^ 8'h5A, 0, 0, 0, 0);
        chk("s5_fill_full", {25'd0, fill_count}, 32'd64);
        for (int i = 0; i < 64; i++) cyc(0, 0, 0, 1, 6'(i), 8'(i) ^ 8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1, 6'(i), 8'hEE, 0, 0, 0, 0);
        chk("s5_fill_hold", {25'd0, fill_count}, 32'd64);
        cyc(0, 0, 0, 1, 2, 8'hEE, 1'b0);
        idle();

        // 6: reset between edges in the middle of a burst
        cyc(1, 0, 8'hC3, 1, 1, 8'hEE, 1'b0);
        idle();
        write = 1'b1; addr_write = 6'd5; data_in = 8'h5C;
        read = 1'b1;  addr_read = 6'd0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_async_data", {24'd0, data_out}, 32'd0);
        chk("s6_async_valid", {31'd0, valid_out}, 32'd0);
        chk("s6_async_fill", {25'd0, fill_count}, 32'd0);
        write = 1'b0; read = 1'b0;
        @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        // entry 0 still holds C3 in the array but is unwritten after reset
        cyc(0, 0, 0, 1, 0, 8'h00, 1'b1);
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
